// File: rtl/vpe_pkg.sv
// Shared definitions for the vector processing element: opcodes, SEW encodings,
// FSM state type and small decode helpers.
package vpe_pkg;

  localparam logic [7:0] OP_VADD  = 8'h00;
  localparam logic [7:0] OP_VMUL  = 8'h01;
  localparam logic [7:0] OP_VDOT  = 8'h02;
  // varp codes are reserved and decode as illegal
  localparam logic [7:0] OP_VARP0 = 8'h03;
  localparam logic [7:0] OP_VARP1 = 8'h04;
  localparam logic [7:0] OP_VARP2 = 8'h05;

  localparam logic [9:0] SEW_W8  = 10'd8;
  localparam logic [9:0] SEW_W16 = 10'd16;
  localparam logic [9:0] SEW_W32 = 10'd32;

  typedef enum logic [1:0] {SEW_8, SEW_16, SEW_32} sew_t;

  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

  function automatic logic op_legal(input logic [7:0] op);
    return (op == OP_VADD) || (op == OP_VMUL) || (op == OP_VDOT);
  endfunction

  function automatic logic sew_legal(input logic [9:0] w, input int xlen);
    return ((w == SEW_W8) || (w == SEW_W16) || (w == SEW_W32)) && (int'(w) <= xlen);
  endfunction

  function automatic sew_t sew_encode(input logic [9:0] w);
    case (w)
      SEW_W16: return SEW_16;
      SEW_W32: return SEW_32;
      default: return SEW_8;
    endcase
  endfunction

  function automatic int sew_bits(input sew_t s);
    case (s)
      SEW_16:  return 16;
      SEW_32:  return 32;
      default: return 8;
    endcase
  endfunction

endpackage

// File: rtl/vpe_lane_mul.sv
// One lane multiplier: SEW x SEW operands taken from the low bits of a/b, sign- or
// zero-extended, producing the exact 64-bit product.
module vpe_lane_mul
  import vpe_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  sew,
  input  logic        is_signed,
  output logic [63:0] prod
);

  logic signed [32:0] a_x;
  logic signed [32:0] b_x;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    a_x = '0;
    b_x = '0;
    case (sew_t'(sew))
      SEW_8: begin
        a_x = {{25{is_signed & a[7]}}, a[7:0]};
        b_x = {{25{is_signed & b[7]}}, b[7:0]};
      end
      SEW_16: begin
        a_x = {{17{is_signed & a[15]}}, a[15:0]};
        b_x = {{17{is_signed & b[15]}}, b[15:0]};
      end
      default: begin
        a_x = {is_signed & a[31], a};
        b_x = {is_signed & b[31], b};
      end
    endcase
  end

  // Operands are signed, so the size casts sign-extend and the low 64 bits are exact.
  assign prod = 64'(a_x) * 64'(b_x);

endmodule

// File: rtl/vector_pe_seq.sv
// Multi-cycle vector element: vadd in one exec cycle, vmul/vdot stepping through
// lanes MUL_PER_CYC at a time, with a start/busy/done handshake.
module vector_pe_seq
  import vpe_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int MUL_PER_CYC = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      instruction,
  input  logic            start,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  input  logic [XLEN-1:0] opC,
  input  logic [9:0]      SEW,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [XLEN-1:0] peout
);

  localparam int MAX_LANES = XLEN / 8;
  localparam int CNT_W     = $clog2(MAX_LANES + MUL_PER_CYC) + 1;

  state_t          state;
  logic [7:0]      op_q;
  sew_t            sew_q;
  logic [XLEN-1:0] a_q, b_q, acc_q, stage_q;
  logic [CNT_W-1:0] cnt_q;

  int               sew_w;
  logic [31:0]      mask32;
  logic [CNT_W-1:0] lane_cnt;
  logic             last_mul;

  logic [MUL_PER_CYC-1:0][CNT_W-1:0] idx;
  logic [MUL_PER_CYC-1:0]            lane_ok;
  int                                sh [MUL_PER_CYC];
  logic [MUL_PER_CYC-1:0][31:0]      lane_a, lane_b;
  logic [MUL_PER_CYC-1:0][63:0]      lane_p;

  logic [XLEN-1:0] vadd_res, stage_nxt, acc_nxt;

  function automatic logic [XLEN-1:0] sext_prod(input logic [63:0] p);
    logic [XLEN+63:0] w;
    w = {{XLEN{p[63]}}, p};
    return w[XLEN-1:0];
  endfunction

  always_comb begin
    sew_w    = sew_bits(sew_q);
    mask32   = 32'hFFFF_FFFF;
    lane_cnt = CNT_W'(XLEN / 32);
    case (sew_q)
      SEW_8: begin
        mask32   = 32'h0000_00FF;
        lane_cnt = CNT_W'(XLEN / 8);
      end
      SEW_16: begin
        mask32   = 32'h0000_FFFF;
        lane_cnt = CNT_W'(XLEN / 16);
      end
      default: ;
    endcase
    last_mul = (cnt_q + CNT_W'(MUL_PER_CYC)) >= lane_cnt;
  end

  // Lane extraction: lanes past L (SEW=32 with MUL_PER_CYC>1) are masked off by lane_ok.
  always_comb begin
    for (int k = 0; k < MUL_PER_CYC; k++) begin
      idx[k]     = cnt_q + CNT_W'(k);
      lane_ok[k] = idx[k] < lane_cnt;
      sh[k]      = int'(idx[k]) * sew_w;
      lane_a[k]  = 32'(a_q >> sh[k]) & mask32;
      lane_b[k]  = 32'(b_q >> sh[k]) & mask32;
    end
  end

  for (genvar k = 0; k < MUL_PER_CYC; k++) begin : g_mul
    vpe_lane_mul u_mul (
      .a         (lane_a[k]),
      .b         (lane_b[k]),
      .sew       (sew_q),
      .is_signed (op_q == OP_VDOT),
      .prod      (lane_p[k])
    );
  end

  always_comb begin
    stage_nxt = stage_q;
    acc_nxt   = acc_q;
    for (int k = 0; k < MUL_PER_CYC; k++) begin
      if (lane_ok[k]) begin
        stage_nxt = (stage_nxt & ~(XLEN'(mask32) << sh[k]))
                  | (XLEN'(lane_p[k][31:0] & mask32) << sh[k]);
        acc_nxt   = acc_nxt + sext_prod(lane_p[k]);
      end
    end
  end

  always_comb begin
    vadd_res = '0;
    case (sew_q)
      SEW_8:
        for (int i = 0; i < XLEN / 8; i++)
          vadd_res[i*8 +: 8] = a_q[i*8 +: 8] + b_q[i*8 +: 8];
      SEW_16:
        for (int i = 0; i < XLEN / 16; i++)
          vadd_res[i*16 +: 16] = a_q[i*16 +: 16] + b_q[i*16 +: 16];
      default:
        for (int i = 0; i < XLEN / 32; i++)
          vadd_res[i*32 +: 32] = a_q[i*32 +: 32] + b_q[i*32 +: 32];
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      peout   <= '0;
      op_q    <= '0;
      sew_q   <= SEW_8;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      stage_q <= '0;
      cnt_q   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q    <= instruction;
            sew_q   <= sew_encode(SEW);
            a_q     <= opA;
            b_q     <= opB;
            acc_q   <= opC;
            stage_q <= '0;
            cnt_q   <= '0;
            err     <= 1'b0;
            if (!op_legal(instruction) || !sew_legal(SEW, XLEN)) begin
              err   <= 1'b1;
              done  <= 1'b1;
              peout <= '0;
              state <= DONE;
            end else if (instruction == OP_VADD) begin
              busy  <= 1'b1;
              state <= EXEC;
            end else begin
              busy  <= 1'b1;
              state <= MUL;
            end
          end
        end
        EXEC: begin
          peout <= vadd_res;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= DONE;
        end
        MUL: begin
          stage_q <= stage_nxt;
          acc_q   <= acc_nxt;
          cnt_q   <= cnt_q + CNT_W'(MUL_PER_CYC);
          if (last_mul) begin
            peout <= (op_q == OP_VDOT) ? acc_nxt : stage_nxt;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_pe_seq.sv
// Self-checking bench for vector_pe_seq: directed cases, handshake and reset
// scenarios, then randomized ops against a lane-by-lane arithmetic model.
module tb_vector_pe_seq;

  localparam int XLEN = 32;
  localparam int MPC  = 1;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [7:0]      instruction = '0;
  logic            start = 1'b0;
  logic [XLEN-1:0] opA = '0, opB = '0, opC = '0;
  logic [9:0]      SEW = 10'd8;
  logic            busy, done, err;
  logic [XLEN-1:0] peout;

  int n_cmp = 0;
  int n_bad = 0;

  vector_pe_seq #(.XLEN(XLEN), .MUL_PER_CYC(MPC)) dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .start       (start),
    .opA         (opA),
    .opB         (opB),
    .opC         (opC),
    .SEW         (SEW),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .peout       (peout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic is_legal(input logic [7:0] ins, input logic [9:0] sew);
    return (ins <= 8'h02) && (sew == 10'd8 || sew == 10'd16 || sew == 10'd32);
  endfunction

  function automatic int model_latency(input logic [7:0] ins, input logic [9:0] sew);
    int cyc;
    if (!is_legal(ins, sew)) return 1;
    if (ins == 8'h00) return 2;
    cyc = (XLEN / int'(sew)) / MPC;
    return 1 + ((cyc < 1) ? 1 : cyc);
  endfunction

  // Lane-by-lane arithmetic on 64-bit integers; vdot sign-extends each element.
  function automatic logic [31:0] model_result(input logic [7:0] ins, input logic [9:0] sew,
                                               input logic [31:0] a, b, c);
    logic [63:0] mask, ea, eb, acc, r;
    int sw, lanes;
    if (!is_legal(ins, sew)) return 32'd0;
    sw    = int'(sew);
    lanes = XLEN / sw;
    mask  = (64'd1 << sw) - 64'd1;
    r     = '0;
    acc   = {{32{c[31]}}, c};
    for (int i = 0; i < lanes; i++) begin
      ea = ({32'd0, a} >> (i * sw)) & mask;
      eb = ({32'd0, b} >> (i * sw)) & mask;
      case (ins)
        8'h00:   r = r | (((ea + eb) & mask) << (i * sw));
        8'h01:   r = r | (((ea * eb) & mask) << (i * sw));
        default: begin
          if (ea[sw-1]) ea = ea | ~mask;
          if (eb[sw-1]) eb = eb | ~mask;
          acc = acc + ea * eb;
        end
      endcase
    end
    return (ins == 8'h02) ? acc[31:0] : r[31:0];
  endfunction

  task automatic run_op(input string tag, input logic [7:0] ins, input logic [9:0] sew,
                        input logic [31:0] a, b, c, input logic [31:0] exp_res);
    int edges;
    logic legal;
    legal = is_legal(ins, sew);
    @(negedge clk);
    instruction = ins; SEW = sew; opA = a; opB = b; opC = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    opA = $urandom; opB = $urandom; opC = $urandom; SEW = 10'd16; instruction = 8'h01;
    check({tag, "_busy_acc"}, 32'(busy), 32'(legal));
    check({tag, "_err_acc"}, 32'(err), 32'(!legal));
    edges = 1;
    while (!done && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    check({tag, "_latency"}, 32'(edges), 32'(model_latency(ins, sew)));
    check({tag, "_peout"}, peout, exp_res);
    check({tag, "_err"}, 32'(err), 32'(!legal));
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_peout_hold"}, peout, exp_res);
  endtask

  initial begin
    int ndone, edges, acc_edge;
    logic [31:0] got, a, b, c, na, nb;
    logic [7:0] ins;
    logic [9:0] sew;

    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_peout", peout, 32'd0);
    @(negedge clk); reset = 1'b0;

    run_op("t1_vadd8", 8'h00, 10'd8, 32'hFF01_7F80, 32'h0101_0180, 32'd0, 32'h0002_8000);
    run_op("t2_vmul16", 8'h01, 10'd16, 32'h0003_FFFF, 32'h0005_0002, 32'd0, 32'h000F_FFFE);
    run_op("t3_vdot8", 8'h02, 10'd8, 32'h0102_03FF, 32'h0101_0102, 32'd10, 32'd14);
    run_op("t4_sew64", 8'h00, 10'd64, 32'h1234_5678, 32'h1111_1111, 32'd0, 32'd0);
    run_op("t4_op04", 8'h04, 10'd8, 32'h1234_5678, 32'h1111_1111, 32'd0, 32'd0);
    run_op("b_vmul32", 8'h01, 10'd32, 32'h0001_0003, 32'h0001_0005, 32'd0, 32'h0008_000F);
    run_op("b_vdot32", 8'h02, 10'd32, 32'hFFFF_FFFE, 32'h0000_0003, 32'd1, 32'hFFFF_FFFB);

    // start re-pulsed while busy must not produce a second done
    @(negedge clk);
    instruction = 8'h02; SEW = 10'd8; opA = 32'h0102_03FF; opB = 32'h0101_0102; opC = 32'd10;
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    ndone = 0; got = '0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    if (done) ndone++;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) begin ndone++; got = peout; end
    end
    check("hs_repulse_dones", 32'(ndone), 32'd1);
    check("hs_repulse_res", got, 32'd14);

    // start held high: second accept lands on the edge after the DONE cycle
    na = 32'h0A0B_0C0D; nb = 32'h0102_0304;
    @(negedge clk);
    instruction = 8'h00; SEW = 10'd8; opA = 32'h1111_1111; opB = 32'h2222_2222; start = 1'b1;
    @(posedge clk); #1;
    opA = na; opB = nb;
    edges = 1; ndone = 0; acc_edge = 0;
    while (ndone < 2 && edges < 20) begin
      @(posedge clk); #1;
      edges++;
      if (done) begin
        ndone++;
        if (ndone == 1) check("hs_hold_res1", peout, 32'h3333_3333);
      end
      if (busy && acc_edge == 0) acc_edge = edges;
    end
    start = 1'b0;
    check("hs_hold_accept2", 32'(acc_edge), 32'd4);
    check("hs_hold_done2", 32'(edges), 32'd5);
    check("hs_hold_res2", peout, model_result(8'h00, 10'd8, na, nb, 32'd0));
    @(posedge clk); #1;

    // asynchronous reset in the MUL state discards the op
    @(negedge clk);
    instruction = 8'h02; SEW = 10'd8; opA = 32'h0102_03FF; opB = 32'h0101_0102; opC = 32'd10;
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_peout", peout, 32'd0);
    @(negedge clk); reset = 1'b0;
    ndone = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("rst_mid_nodone", 32'(ndone), 32'd0);
    run_op("rst_after_vdot", 8'h02, 10'd8, 32'h0102_03FF, 32'h0101_0102, 32'd10, 32'd14);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: sew = 10'd8;
        3, 4, 5: sew = 10'd16;
        6, 7, 8: sew = 10'd32;
        default: sew = ($urandom_range(0, 1) == 0) ? 10'd64 : 10'd24;
      endcase
      ins = ($urandom_range(0, 9) == 0) ? 8'(3 + $urandom_range(0, 2)) : 8'($urandom_range(0, 2));
      a = $urandom; b = $urandom; c = $urandom;
      run_op($sformatf("rnd%0d", n), ins, sew, a, b, c, model_result(ins, sew, a, b, c));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
